mcycle_bus_ctrl: RTL and testbench
==================================

# mcycle_bus_ctrl

Bus responder for the SM83 core: it accepts the core's per-M-cycle bus requests (`bus_opcode_t`: IDLE, IF, WRITE, READ, IF_CB) and sequences each one into T-state-accurate memory strobes over a 4-T-cycle M-cycle. It stalls on memory wait, aborts after a bounded wait, and returns read or fetch data to the core's decode and register-file path. It sits between the core and the memory map/arbiter.

## Interface
- `TCYC`, 4: T-cycles per M-cycle. Fixed at 4; other values are unsupported.
- `MAX_WAIT`, 15: maximum stall cycles inserted in T2 before the request is aborted (1..15).
- `clk` in 1: T-cycle clock.
- `rst` in 1: synchronous, active-high reset.
- `req_op` in 3: `cpu_pkg::bus_opcode_t` for the next M-cycle. Encodings 5..7 are treated as IDLE.
- `req_addr` in 16: address for the next M-cycle (an already-resolved 16-bit address, including 0xFF00+Z/C).
- `req_wdata` in 8: write data for the next M-cycle.
- `tstate` out 2: current T-state, 0..3.
- `mcycle_start` out 1: high while `tstate==0`.
- `rsp_valid` out 1: one-cycle pulse in T3 of every non-IDLE M-cycle.
- `rsp_data` out 8: read/fetch data, valid while `rsp_valid`; holds its value otherwise.
- `rsp_opcode` out 1: the completed op was IF or IF_CB.
- `rsp_cb` out 1: the completed op was IF_CB.
- `bus_err` out 1: one-cycle pulse in T3 when the request was aborted by wait timeout.
- `mem_addr` out 16, `mem_rd` out 1, `mem_wr` out 1, `mem_wdata` out 8: memory side.
- `mem_rdata` in 8, `mem_wait` in 1: memory side.

## Operation
- A free-running T counter runs 0→1→2→3→0. It holds only at T2 while stalling.
- Request capture: on the clock edge that leaves T3, `req_op`, `req_addr` and `req_wdata` are latched into `cur_*`. The core drives the next request during T3, typically in reaction to `rsp_valid`.
- Outside T3, request inputs are ignored.
- READ, IF, IF_CB:
  - `mem_addr=cur_addr` for T0..T3.
  - `mem_rd` is high in T1 and T2, including stall cycles.
  - `mem_rdata` is latched into `rsp_data` on the edge leaving T2 (the edge on which the counter advances).
- WRITE:
  - `mem_addr` for T0..T3; `mem_wdata=cur_wdata` for T1..T3.
  - `mem_wr` is high in T2, including stall cycles.
  - `rsp_data` is unchanged.
- IDLE:
  - No strobes; `mem_addr` holds its previous value.
  - No `rsp_valid` and no stalls; `mem_wait` is ignored.
- Wait handling:
  - `mem_wait` is sampled only in T2 of a non-IDLE cycle.
  - While it is high and `wait_cnt<MAX_WAIT`, the counter stays at T2 and `wait_cnt` increments.
  - If `mem_wait` is still high when `wait_cnt==MAX_WAIT`, the cycle is forced to T3: a read loads `rsp_data=0xFF`, and `bus_err` pulses with `rsp_valid` in T3.
  - `wait_cnt` clears at T0.
- Flags: `rsp_opcode` and `rsp_cb` are decoded from `cur_op`. Both are 0 for READ and WRITE.
- Reset (any T-state, including mid-stall):
  - Next cycle: `tstate=0`, `cur_op=IDLE`, `mem_rd=mem_wr=0`, `mem_addr=0x0000`, `mem_wdata=0x00`, `rsp_data=0x00`, `rsp_valid=rsp_opcode=rsp_cb=bus_err=0`, `wait_cnt=0`.
  - Consequently the first M-cycle after reset is always IDLE.
  - An interrupted request produces no response.

## Timing
- All outputs are registered, except `mcycle_start` and the flags decoded from registered state.
- Latency: request latched at the end of T3(n); response `rsp_valid` in T3(n+1), 4 cycles later plus any stall cycles.
- Back-to-back requests sustain one access per 4 cycles.
- `mem_rd` and `mem_wr` are never high in the same cycle, and both are low in T0 and T3.
- A stall of k cycles (k≤MAX_WAIT) lengthens the M-cycle to 4+k cycles. An aborted cycle lasts 4+MAX_WAIT cycles.
- If `mem_wait` deasserts in the same cycle that `wait_cnt` reaches MAX_WAIT, the cycle completes normally (no error).

## Test plan
- Reset, then READ 0xC000 with `mem_rdata=0x5A` and no wait:
  - M-cycle 1 is IDLE.
  - In M-cycle 2, `mem_rd` is high in T1–T2, and T3 shows `rsp_valid=1`, `rsp_data=0x5A`, `rsp_opcode=0`.
- IF_CB at 0x0150 returning 0x37:
  - `rsp_valid`, `rsp_opcode=1`, `rsp_cb=1`, `rsp_data=0x37`.
  - A following IF returns `rsp_cb=0`.
- WRITE 0xFF80 ← 0xA5:
  - `mem_wr` is high only in T2 with `mem_wdata=0xA5`.
  - `rsp_data` keeps its prior value.
  - Back-to-back WRITE/READ are spaced exactly 4 cycles apart.
- READ with `mem_wait` high for 3 cycles:
  - `tstate` holds at 2 for 4 cycles total and the M-cycle is 7 cycles long.
  - Data is latched after wait drops; no `bus_err`.
- READ with `mem_wait` stuck high (MAX_WAIT=15):
  - The M-cycle is 19 cycles long.
  - T3 shows `rsp_data=0xFF`, `bus_err=1`, `rsp_valid=1`.
  - The next request proceeds normally.
- Assert `rst` during a T2 stall of a WRITE:
  - `mem_wr` is low the next cycle, `tstate=0`, and no `rsp_valid` or `bus_err` follows.
  - `req_op=6` afterwards behaves as IDLE.

Source files
------------

// File: rtl/mcycle_bus_ctrl.sv
// mcycle_bus_ctrl: sequences SM83 per-M-cycle bus requests into T-state
// accurate memory strobes, with bounded wait stalls and response return.

package cpu_pkg;
  typedef enum logic [2:0] {
    BUS_IDLE  = 3'd0,
    BUS_IF    = 3'd1,
    BUS_WRITE = 3'd2,
    BUS_READ  = 3'd3,
    BUS_IF_CB = 3'd4
  } bus_opcode_t;
endpackage

// state | meaning
// T0    | address phase; wait counter cleared
// T1    | read strobe begins (read/fetch ops)
// T2    | strobe phase; holds here while memory waits, aborts at MAX_WAIT
// T3    | response slot; next request captured on the edge leaving T3
module mcycle_bus_ctrl #(
  parameter int TCYC     = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic [1:0]  tstate,
  output logic        mcycle_start,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_opcode,
  output logic        rsp_cb,
  output logic        bus_err,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_wait
);
  import cpu_pkg::*;

  localparam logic [1:0] T_LAST = 2'(TCYC - 1);
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = T_LAST
  } tstate_t;

  tstate_t     tstate_q, tstate_d;
  bus_opcode_t cur_op_q, cur_op_d;
  logic [7:0]  cur_wdata_q, cur_wdata_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        bus_err_q, bus_err_d;

  bus_opcode_t req_op_norm;
  logic        cur_is_rd, cur_is_wr, cur_active, abort, leave_t2;

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      tstate_q    <= T0;
      cur_op_q    <= BUS_IDLE;
      cur_wdata_q <= 8'h00;
      wait_cnt_q  <= 4'd0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      tstate_q    <= tstate_d;
      cur_op_q    <= cur_op_d;
      cur_wdata_q <= cur_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // T-state sequencing, wait handling, request capture and strobe generation
  always_comb begin
    tstate_d    = tstate_q;
    cur_op_d    = cur_op_q;
    cur_wdata_d = cur_wdata_q;
    wait_cnt_d  = wait_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;
    abort       = 1'b0;

    // Unused encodings behave as IDLE so they never strobe memory.
    case (req_op)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: req_op_norm = bus_opcode_t'(req_op);
      default:                      req_op_norm = BUS_IDLE;
    endcase

    cur_is_rd  = (cur_op_q == BUS_READ) || (cur_op_q == BUS_IF) || (cur_op_q == BUS_IF_CB);
    cur_is_wr  = (cur_op_q == BUS_WRITE);
    cur_active = (cur_op_q != BUS_IDLE);

    unique case (tstate_q)
      T0: begin
        tstate_d   = T1;
        wait_cnt_d = 4'd0;
        if (cur_is_wr) mem_wdata_d = cur_wdata_q;
      end
      T1: tstate_d = T2;
      T2: begin
        if (cur_active && mem_wait) begin
          if (wait_cnt_q < WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end else begin
            abort    = 1'b1;
            tstate_d = T3;
          end
        end else begin
          tstate_d = T3;
        end
      end
      T3: begin
        tstate_d    = T0;
        cur_op_d    = req_op_norm;
        cur_wdata_d = req_wdata;
        // IDLE cycles leave the address bus where it was.
        if (req_op_norm != BUS_IDLE) mem_addr_d = req_addr;
      end
    endcase

    leave_t2 = (tstate_q == T2) && (tstate_d == T3);
    if (leave_t2 && cur_is_rd) rsp_data_d = abort ? 8'hFF : mem_rdata;

    mem_rd_d    = cur_is_rd && ((tstate_d == T1) || (tstate_d == T2));
    mem_wr_d    = cur_is_wr && (tstate_d == T2);
    rsp_valid_d = cur_active && leave_t2;
    bus_err_d   = rsp_valid_d && abort;
  end

  assign tstate       = tstate_q;
  assign mcycle_start = (tstate_q == T0);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_opcode   = (cur_op_q == BUS_IF) || (cur_op_q == BUS_IF_CB);
  assign rsp_cb       = (cur_op_q == BUS_IF_CB);
  assign bus_err      = bus_err_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mcycle_bus_ctrl.sv
// Scoreboard bench for mcycle_bus_ctrl: driver issues requests and pushes
// reference-model expectations; a monitor emulates memory and checks.

module tb_mcycle_bus_ctrl;
  localparam int MAXW = 15;
  localparam logic [2:0] OP_IDLE = 3'd0, OP_IF = 3'd1, OP_WRITE = 3'd2,
                         OP_READ = 3'd3, OP_IF_CB = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_op;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [1:0]  tstate;
  logic        mcycle_start, rsp_valid, rsp_opcode, rsp_cb, bus_err;
  logic [7:0]  rsp_data;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_wait;

  mcycle_bus_ctrl #(.TCYC(4), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .tstate(tstate), .mcycle_start(mcycle_start), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_opcode(rsp_opcode), .rsp_cb(rsp_cb), .bus_err(bus_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_wait(mem_wait)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  data;
    logic        err;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  logic [7:0] bench_mem [int];
  logic [7:0] ref_mem [int];
  logic [7:0] ref_last;

  logic [2:0]  pend_op, act_op;
  logic [15:0] pend_addr, act_addr;
  logic [7:0]  pend_wdata, act_wdata;
  int          pend_stall, act_stall, stall_done;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] bmem_rd(input logic [15:0] a);
    if (bench_mem.exists(int'(a))) return bench_mem[int'(a)];
    return dflt(a);
  endfunction

  function automatic logic [7:0] rmem_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return dflt(a);
  endfunction

  function automatic bit is_rd_op(input logic [2:0] op);
    return (op == OP_IF) || (op == OP_READ) || (op == OP_IF_CB);
  endfunction

  // Memory emulation plus per-cycle strobe checks and response scoreboard
  always @(negedge clk) begin
    if (rst) begin
      act_op     = OP_IDLE;
      act_stall  = 0;
      stall_done = 0;
      mem_wait   = 1'b0;
    end else begin
      if (tstate == 2'd0) begin
        act_op     = pend_op;
        act_addr   = pend_addr;
        act_wdata  = pend_wdata;
        act_stall  = pend_stall;
        stall_done = 0;
      end
      chk("mcycle_start", 32'(mcycle_start), 32'(tstate == 2'd0));
      chk("mem_rd", 32'(mem_rd), 32'(is_rd_op(act_op) && (tstate == 2'd1 || tstate == 2'd2)));
      chk("mem_wr", 32'(mem_wr), 32'(act_op == OP_WRITE && tstate == 2'd2));
      if (mem_rd || mem_wr) chk("mem_addr", 32'(mem_addr), 32'(act_addr));
      if (mem_wr) chk("mem_wdata", 32'(mem_wdata), 32'(act_wdata));

      if (rsp_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(e.exp_cyc));
          chk("rsp_tstate", 32'(tstate), 32'd3);
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_opcode", 32'(rsp_opcode), 32'(e.op == OP_IF || e.op == OP_IF_CB));
          chk("rsp_cb", 32'(rsp_cb), 32'(e.op == OP_IF_CB));
          chk("bus_err", 32'(bus_err), 32'(e.err));
          if (e.op == OP_WRITE) chk("write_mem", 32'(bmem_rd(e.addr)), 32'(e.wdata));
        end
      end else if (bus_err) begin
        chk("bus_err_alone", 32'(bus_err), 32'd0);
      end

      if (mem_wr) bench_mem[int'(mem_addr)] = mem_wdata;
      mem_rdata = mem_rd ? bmem_rd(mem_addr) : 8'($urandom);
      if (tstate == 2'd2 && act_op != OP_IDLE) begin
        mem_wait = (stall_done < act_stall);
        if (mem_wait) stall_done++;
      end else begin
        mem_wait = 1'($urandom_range(0, 1));
      end
    end
  end

  // Advance to the next T3 negedge; request inputs get junk elsewhere.
  task automatic wait_t3();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (tstate != 2'd3) begin
        req_op    = 3'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 8'($urandom);
      end
    end while (tstate != 2'd3 && n < 100);
    if (tstate != 2'd3) begin
      $display("FAIL t3_timeout: got tstate=%0d expected 3 within 100 cycles", tstate);
      $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
      $fatal(1);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [7:0] wd,
                       input int stall);
    logic [2:0] n;
    exp_t e;
    wait_t3();
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    n = (op > OP_IF_CB) ? OP_IDLE : op;
    pend_op    = n;
    pend_addr  = a;
    pend_wdata = wd;
    pend_stall = (n == OP_IDLE) ? 0 : stall;
    if (n != OP_IDLE) begin
      e.op      = n;
      e.addr    = a;
      e.wdata   = wd;
      e.err     = (stall > MAXW);
      e.exp_cyc = cyc + 4 + ((stall > MAXW) ? MAXW : stall);
      if (n == OP_WRITE) begin
        ref_mem[int'(a)] = wd;
        e.data = ref_last;
      end else begin
        e.data   = e.err ? 8'hFF : rmem_rd(a);
        ref_last = e.data;
      end
      sb.push_back(e);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_tstate", 32'(tstate), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_rsp_opcode", 32'(rsp_opcode), 32'd0);
    chk("rst_rsp_cb", 32'(rsp_cb), 32'd0);
  endtask

  initial begin
    int n, r, st;
    logic [15:0] a;
    rst = 1'b1;
    req_op = OP_IDLE; req_addr = 16'h0; req_wdata = 8'h0;
    mem_rdata = 8'h00; mem_wait = 1'b0;
    pend_op = OP_IDLE; pend_addr = 16'h0; pend_wdata = 8'h0; pend_stall = 0;
    act_op = OP_IDLE; act_addr = 16'h0; act_wdata = 8'h0; act_stall = 0; stall_done = 0;
    ref_last = 8'h00;
    bench_mem[16'hC000] = 8'h5A; ref_mem[16'hC000] = 8'h5A;
    bench_mem[16'h0150] = 8'h37; ref_mem[16'h0150] = 8'h37;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    issue(OP_READ,  16'hC000, 8'h00, 0);
    issue(OP_IF_CB, 16'h0150, 8'h00, 0);
    issue(OP_IF,    16'h0151, 8'h00, 0);
    issue(OP_WRITE, 16'hFF80, 8'hA5, 0);
    issue(OP_READ,  16'hFF80, 8'h00, 0);
    issue(OP_READ,  16'hC001, 8'h00, 3);
    issue(OP_READ,  16'hC002, 8'h00, 20);
    issue(OP_READ,  16'hC003, 8'h00, 0);
    issue(OP_READ,  16'hC004, 8'h00, MAXW);
    issue(OP_WRITE, 16'hC005, 8'h55, 18);
    issue(OP_READ,  16'hC005, 8'h00, 0);
    issue(3'd7,     16'h1234, 8'h00, 0);

    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      st = (r <= 5) ? 0 : (r <= 7) ? $urandom_range(1, 4)
         : (r == 8) ? $urandom_range(MAXW, MAXW + 1) : $urandom_range(MAXW + 1, MAXW + 5);
      a  = ($urandom_range(0, 1) == 1) ? {13'h1800, 3'($urandom)} : 16'($urandom);
      issue(3'($urandom_range(0, 7)), a, 8'($urandom), st);
    end

    // Reset in the middle of a stalled write
    issue(OP_WRITE, 16'hFF81, 8'h3C, 30);
    n = 0;
    while (!(mem_wr && tstate == 2'd2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reached", 32'(mem_wr), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    pend_op = OP_IDLE; pend_stall = 0;
    @(negedge clk);
    check_reset_state();
    ref_last = 8'h00;
    rst = 1'b0;

    issue(3'd6, 16'hFF81, 8'h11, 0);
    issue(3'd6, 16'hFF82, 8'h22, 0);
    issue(OP_READ, 16'hFF81, 8'h00, 0);
    issue(OP_IDLE, 16'h0000, 8'h00, 0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
